fft_transpose_feeder: RTL

Corner-turn buffer between the row FFT and the column FFT of the 2D FFT datapath. It accepts one N×N frame of complex samples in row-major order on an AXI-Stream slave port, which is the first FFT core's output. It replays the frame in column-major order on an AXI-Stream master port with correct tvalid/tready/tlast handshaking, so it can drive the second FFT core's data input directly. Single buffer: fill the whole frame, drain it, then accept the next frame.

---
 rtl/fft_transpose_feeder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fft_transpose_feeder.sv
// Corner-turn buffer: captures one N x N frame row-major on an AXI-Stream slave
// and replays it column-major on an AXI-Stream master, one frame at a time.
module fft_transpose_feeder #(
    parameter int N      = 128,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              tlast_err,
    output logic              frame_done
);

    localparam int LOG2N = $clog2(N);
    localparam int CNT_W = 2 * LOG2N;
    localparam int DEPTH = N * N;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH - 1);
    localparam logic [LOG2N-1:0] ROW_MAX = LOG2N'(N - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic             rd_all;

    logic [DATA_W-1:0] rd_data_p1;
    logic              vld_p1;
    logic              last_p1;
    logic              final_p1;

    logic             s_accept;
    logic             m_accept;
    logic             final_accept;
    logic             rd_issue;
    logic             exp_last;
    logic [LOG2N-1:0] rd_row;
    logic [LOG2N-1:0] rd_col;
    logic [CNT_W-1:0] rd_addr;

    // Input is held off while reset is asserted regardless of the state register.
    assign s_axis_tready = (state_q == FILL) && rst_n;
    assign s_accept      = s_axis_tvalid && s_axis_tready;
    assign exp_last      = (wr_cnt[LOG2N-1:0] == ROW_MAX);

    // Row index runs fastest so consecutive reads walk down a column.
    assign rd_row   = rd_cnt[LOG2N-1:0];
    assign rd_col   = rd_cnt[CNT_W-1:LOG2N];
    assign rd_addr  = {rd_row, rd_col};

    assign m_accept     = vld_p1 && m_axis_tready;
    assign final_accept = m_accept && final_p1;
    assign rd_issue     = (state_q == DRAIN) && !rd_all && (!vld_p1 || m_axis_tready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (s_accept && (wr_cnt == CNT_MAX)) state_d = DRAIN;
            DRAIN:   if (final_accept) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FILL;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            rd_all     <= 1'b0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            final_p1   <= 1'b0;
            tlast_err  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            tlast_err  <= s_accept && (s_axis_tlast != exp_last);
            frame_done <= final_accept;
            if (s_accept) wr_cnt <= wr_cnt + 1'b1;
            if (final_accept) begin
                rd_cnt <= '0;
                rd_all <= 1'b0;
            end else if (rd_issue) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt == CNT_MAX) rd_all <= 1'b1;
            end
            // p0 -> p1: issued read becomes the registered output beat
            if (rd_issue) begin
                vld_p1   <= 1'b1;
                last_p1  <= (rd_row == ROW_MAX);
                final_p1 <= (rd_cnt == CNT_MAX);
            end else if (m_accept) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s_accept) mem[wr_cnt] <= s_axis_tdata;
        if (rd_issue) rd_data_p1 <= mem[rd_addr];
    end

    assign m_axis_tdata  = rd_data_p1;
    assign m_axis_tvalid = vld_p1;
    assign m_axis_tlast  = last_p1;

endmodule
